clahe_clip_cdf: RTL and testbench
=================================

Name: clahe_clip_cdf

Overview:
- Post-histogram stage. On frame_hist_done from the histogram statistics block, walks every tile's 256-bin histogram from the idle ping-pong bank.
- Per tile: applies the contrast clip limit, redistributes the clipped excess uniformly, accumulates the CDF, and writes a scaled 8-bit mapping LUT.
- The LUT feeds the pixel-mapping/interpolation stage for the next frame.

Parameters:
- NUM_TILES, 16: tiles per frame; tile index width is clog2(NUM_TILES).
- TILE_PIXELS, 57600: pixels per tile (320x180).
- SCALE_MULT, 74275: CDF-to-LUT reciprocal, ceil(255*2^SCALE_SHIFT/TILE_PIXELS).
- SCALE_SHIFT, 24: right shift applied after the multiply.

Ports:
- pclk, in, 1: clock.
- rst_n, in, 1: asynchronous active-low reset.
- start, in, 1: one-cycle pulse; connect to frame_hist_done.
- ping_pong_flag, in, 1: bank the histogram block is currently writing.
- clip_limit, in, 16: per-bin clip threshold; 0 disables clipping.
- hist_rd_bank, out, 1: histogram bank to read (~ping_pong_flag latched at start).
- hist_rd_tile, out, 4: tile index for the histogram read.
- hist_rd_addr, out, 8: bin address for the histogram read.
- hist_rd_data, in, 16: bin count; valid 1 cycle after the address.
- lut_wr_en, out, 1: LUT write strobe.
- lut_wr_bank, out, 1: LUT bank (same latched value as hist_rd_bank).
- lut_wr_tile, out, 4: LUT tile index.
- lut_wr_addr, out, 8: LUT entry address.
- lut_wr_data, out, 8: mapped grey value.
- busy, out, 1: high from the cycle after an accepted start until done.
- done, out, 1: one-cycle pulse after the last LUT write of the last tile.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, counters and accumulators 0. Reset mid-operation aborts immediately; no further writes; restart requires a new start.
- Start acceptance:
  - start is accepted only in IDLE; start while busy is ignored (no restart, no queue).
  - On accept, latch clip_limit, bank=~ping_pong_flag, tile=0.
- FSM states: IDLE -> P1 -> P1_DRAIN -> REDIST -> P2 -> P2_DRAIN -> NEXT -> (P1 | FIN) -> IDLE.
- P1 (256 cycles): issue hist_rd_addr=0..255, one address per cycle.
  - Data for address k returns one cycle later.
  - excess += (clip_limit!=0 && d>clip_limit) ? d-clip_limit : 0.
  - P1_DRAIN absorbs the last returning word.
  - excess accumulator is 17 bits and cannot overflow because total ≤ TILE_PIXELS.
- REDIST (1 cycle): share=excess>>8, rem=excess[7:0].
- P2 (256 cycles): re-read bins 0..255.
  - new_k = min(d,clip) + share + (k<rem ? 1 : 0); without clipping, new_k = d.
  - cdf += new_k (17-bit).
  - lut_k = min(255, (cdf*SCALE_MULT)>>SCALE_SHIFT), using the full 34-bit product.
  - The write issues 1 cycle after data returns: lut_wr_en high for 256 consecutive cycles, starting in the cycle after the first P2 data.
  - lut_wr_addr equals the bin index, in ascending order.
  - Sum of new_k equals the original tile sum; no counts are lost.
- NEXT (1 cycle): clear excess and cdf. If tile==NUM_TILES-1, go to FIN; otherwise tile+1 and go to P1.
- FIN: assert done for 1 cycle, drop busy, return to IDLE.
- Throughput: 516 cycles per tile. done fires NUM_TILES*516+1 cycles after the start cycle.
- The histogram bank is only read, never written. Clearing remains owned by the histogram stage.
- hist_rd_tile / lut_wr_tile are held constant for the whole tile, including drain cycles.

Test Plan:
- Uniform tile, 225 in every bin, clip_limit=1000 -> excess=0.
  - lut[0]=0, lut[127]=127, lut[255]=255.
  - Exactly 256 writes per tile.
- Spike tile, 57600 in bin 100, clip_limit=1000 -> excess=56600, share=221, rem=24.
  - new bins 0..23=222, bins 24..255=221, bin100=1221.
  - lut[23]=23, lut[255]=255.
- clip_limit=0 with the spike tile -> no redistribution.
  - lut[0..99]=0, lut[100..255]=255.
- Full 16-tile run with start pulse at T -> done pulses exactly at T+8257.
  - busy is high T+1..T+8256.
  - 4096 LUT writes total, with tiles in order 0..15.
- ping_pong_flag=1 at start, toggled mid-run -> hist_rd_bank and lut_wr_bank stay 0 throughout.
  - A second start during busy is ignored.
- Assert rst_n low mid-P2 of tile 5 -> all outputs 0 next cycle, no further writes.
  - A new start after reset processes from tile 0.

Source files
------------

// File: rtl/clahe_clip_cdf_if.sv
// Histogram-read / LUT-write bus of the CLAHE clip + CDF stage.
// The master side is the surrounding frame logic: it owns start, the bank
// flag, the clip threshold and the histogram read data. The slave side is
// the clip/CDF engine.
interface clahe_clip_cdf_if #(
    parameter int TILE_W = 4
);
    logic              start;
    logic              ping_pong_flag;
    logic [15:0]       clip_limit;

    logic              hist_rd_bank;
    logic [TILE_W-1:0] hist_rd_tile;
    logic [7:0]        hist_rd_addr;
    logic [15:0]       hist_rd_data;

    logic              lut_wr_en;
    logic              lut_wr_bank;
    logic [TILE_W-1:0] lut_wr_tile;
    logic [7:0]        lut_wr_addr;
    logic [7:0]        lut_wr_data;

    logic              busy;
    logic              done;

    modport master (
        output start, ping_pong_flag, clip_limit, hist_rd_data,
        input  hist_rd_bank, hist_rd_tile, hist_rd_addr,
        input  lut_wr_en, lut_wr_bank, lut_wr_tile, lut_wr_addr, lut_wr_data,
        input  busy, done
    );

    modport slave (
        input  start, ping_pong_flag, clip_limit, hist_rd_data,
        output hist_rd_bank, hist_rd_tile, hist_rd_addr,
        output lut_wr_en, lut_wr_bank, lut_wr_tile, lut_wr_addr, lut_wr_data,
        output busy, done
    );
endinterface

// File: rtl/clahe_clip_cdf.sv
// CLAHE clip-limit / redistribution / CDF stage.
// For every tile the 256-bin histogram is read twice from the idle bank:
// pass 1 sums the excess above the clip limit, pass 2 rebuilds each bin as
// min(bin, clip) + uniform share of the excess, accumulates the CDF and
// writes the scaled 8-bit mapping LUT one cycle after each bin returns.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | waiting for start (frame_hist_done)
// S_P1       | pass 1: issue bin reads 0..255, accumulate clip excess
// S_P1_DRAIN | absorb the last pass-1 read word
// S_REDIST   | split the excess into per-bin share and remainder
// S_P2       | pass 2: re-read bins, build clipped CDF, write LUT
// S_P2_DRAIN | absorb the last pass-2 read word
// S_NEXT     | last LUT write of the tile; clear accumulators, next tile
// S_FIN      | done pulse, back to idle
module clahe_clip_cdf #(
    parameter int NUM_TILES   = 16,
    parameter int TILE_PIXELS = 57600,
    parameter int SCALE_MULT  = 74275,
    parameter int SCALE_SHIFT = 24
) (
    input  logic pclk,
    input  logic rst_n,
    clahe_clip_cdf_if.slave io_bus
);

    localparam int TILE_W = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1;
    // One guard bit above what a full tile needs, so the CDF / excess sums
    // have headroom even with a worst-case +1 remainder on every bin.
    localparam int ACC_W  = $clog2(TILE_PIXELS + 1) + 1;
    localparam int SHR_W  = ACC_W - 8;
    localparam int PROD_W = 2 * ACC_W;

    localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);
    localparam logic [ACC_W-1:0]  MULT      = ACC_W'(SCALE_MULT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_P1,
        S_P1_DRAIN,
        S_REDIST,
        S_P2,
        S_P2_DRAIN,
        S_NEXT,
        S_FIN
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [15:0]       r_clip;
    logic              r_bank;
    logic [TILE_W-1:0] r_tile;
    logic [7:0]        r_addr;
    logic [7:0]        r_rd_idx;
    logic              r_vld_p1;
    logic              r_vld_p2;
    logic [ACC_W-1:0]  r_excess;
    logic [SHR_W-1:0]  r_share;
    logic [7:0]        r_rem;
    logic [ACC_W-1:0]  r_cdf;
    logic              r_wr_en;
    logic [7:0]        r_wr_addr;
    logic [7:0]        r_wr_data;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic              w_over;
    logic [15:0]       w_excess_inc;
    logic [15:0]       w_clipped;
    logic [ACC_W-1:0]  w_bonus;
    logic [ACC_W-1:0]  w_new;
    logic [ACC_W-1:0]  w_cdf;
    logic [PROD_W-1:0] w_prod;
    logic [PROD_W-1:0] w_scaled;
    logic [7:0]        w_lut;

    assign w_accept = (r_state == S_IDLE) && io_bus.start;

    // A zero clip limit means "no clipping": nothing is ever over the limit,
    // so the excess stays zero and share/remainder collapse to zero as well.
    assign w_over       = (r_clip != 16'd0) && (io_bus.hist_rd_data > r_clip);
    assign w_excess_inc = w_over ? (io_bus.hist_rd_data - r_clip) : 16'd0;
    assign w_clipped    = w_over ? r_clip : io_bus.hist_rd_data;

    // The remainder goes one count each to the lowest-numbered bins.
    assign w_bonus  = (r_rd_idx < r_rem) ? ACC_W'(1) : '0;
    assign w_new    = ACC_W'(w_clipped) + ACC_W'(r_share) + w_bonus;
    assign w_cdf    = r_cdf + w_new;
    assign w_prod   = PROD_W'(w_cdf) * PROD_W'(MULT);
    assign w_scaled = w_prod >> SCALE_SHIFT;
    // The reciprocal is rounded up, so a full tile lands marginally above
    // 255.0; saturate rather than wrap.
    assign w_lut    = (w_scaled > PROD_W'(255)) ? 8'hFF : w_scaled[7:0];

    // State register.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (io_bus.start) w_next = S_P1;
            S_P1:       if (r_addr == 8'hFF) w_next = S_P1_DRAIN;
            S_P1_DRAIN: w_next = S_REDIST;
            S_REDIST:   w_next = S_P2;
            S_P2:       if (r_addr == 8'hFF) w_next = S_P2_DRAIN;
            S_P2_DRAIN: w_next = S_NEXT;
            S_NEXT:     w_next = (r_tile == LAST_TILE) ? S_FIN : S_P1;
            S_FIN:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Read address generation and one-cycle read-latency alignment.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr   <= '0;
            r_rd_idx <= '0;
            r_vld_p1 <= 1'b0;
            r_vld_p2 <= 1'b0;
        end else begin
            if (r_state == S_P1 || r_state == S_P2) begin
                r_addr <= r_addr + 8'd1;
            end else begin
                r_addr <= '0;
            end
            r_rd_idx <= r_addr;
            r_vld_p1 <= (r_state == S_P1);
            r_vld_p2 <= (r_state == S_P2);
        end
    end

    // Per-frame configuration and tile sequencing.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_clip <= '0;
            r_bank <= 1'b0;
            r_tile <= '0;
        end else if (w_accept) begin
            r_clip <= io_bus.clip_limit;
            r_bank <= ~io_bus.ping_pong_flag;
            r_tile <= '0;
        end else if (r_state == S_NEXT && r_tile != LAST_TILE) begin
            r_tile <= r_tile + TILE_W'(1);
        end
    end

    // Excess, redistribution and CDF accumulators.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_excess <= '0;
            r_share  <= '0;
            r_rem    <= '0;
            r_cdf    <= '0;
        end else if (w_accept || r_state == S_NEXT) begin
            r_excess <= '0;
            r_share  <= '0;
            r_rem    <= '0;
            r_cdf    <= '0;
        end else begin
            if (r_vld_p1) begin
                r_excess <= r_excess + ACC_W'(w_excess_inc);
            end
            if (r_state == S_REDIST) begin
                r_share <= r_excess[ACC_W-1:8];
                r_rem   <= r_excess[7:0];
            end
            if (r_vld_p2) begin
                r_cdf <= w_cdf;
            end
        end
    end

    // LUT write port, registered one cycle behind the returning bin.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else begin
            r_wr_en   <= r_vld_p2;
            r_wr_addr <= r_vld_p2 ? r_rd_idx : 8'd0;
            r_wr_data <= r_vld_p2 ? w_lut : 8'd0;
        end
    end

    // Status flags, registered from the next state so they align with it.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE) && (w_next != S_FIN);
            r_done <= (w_next == S_FIN);
        end
    end

    assign io_bus.hist_rd_bank = r_bank;
    assign io_bus.hist_rd_tile = r_tile;
    assign io_bus.hist_rd_addr = r_addr;
    assign io_bus.lut_wr_en    = r_wr_en;
    assign io_bus.lut_wr_bank  = r_bank;
    assign io_bus.lut_wr_tile  = r_tile;
    assign io_bus.lut_wr_addr  = r_wr_addr;
    assign io_bus.lut_wr_data  = r_wr_data;
    assign io_bus.busy         = r_busy;
    assign io_bus.done         = r_done;

endmodule

// File: tb/tb_clahe_clip_cdf.sv
// Directed bench for clahe_clip_cdf: histogram memory model, LUT capture
// monitor, full-frame timing checks and a table of hand-computed LUT values.
module tb_clahe_clip_cdf;

    logic pclk  = 1'b0;
    logic rst_n = 1'b0;

    clahe_clip_cdf_if #(.TILE_W(4)) bus ();

    clahe_clip_cdf #(
        .NUM_TILES  (16),
        .TILE_PIXELS(57600),
        .SCALE_MULT (74275),
        .SCALE_SHIFT(24)
    ) dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .io_bus(bus)
    );

    always #5 pclk = ~pclk;

    // Histogram content: tiles whose (tile parity ^ bank) is 0 are uniform
    // (225 per bin), the others hold all 57600 pixels in bin 100.
    function automatic logic [15:0] hist_val(input logic bank, input logic [3:0] tile,
                                             input logic [7:0] bin);
        if ((tile[0] ^ bank) == 1'b0) return 16'd225;
        return (bin == 8'd100) ? 16'd57600 : 16'd0;
    endfunction

    // Synchronous-read histogram memory, one cycle of latency.
    always @(posedge pclk)
        bus.hist_rd_data <= hist_val(bus.hist_rd_bank, bus.hist_rd_tile, bus.hist_rd_addr);

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int         wr_total    = 0;
    int         order_err   = 0;
    int         bank_err    = 0;
    int         done_count  = 0;
    int         done_cyc    = 0;
    int         busy_first  = 0;
    int         busy_last   = 0;
    int         busy_cycles = 0;
    logic       prev_busy   = 1'b0;
    int         mon_tile    = 0;
    int         mon_addr    = 0;
    logic       exp_bank    = 1'b0;
    logic [7:0] lut_cap [16][256];

    // Output monitor: captures LUT writes, checks write order and bank.
    always @(negedge pclk) begin
        if (!rst_n) begin
            mon_tile  = 0;
            mon_addr  = 0;
            prev_busy = 1'b0;
        end else begin
            if (bus.lut_wr_en) begin
                wr_total++;
                lut_cap[bus.lut_wr_tile][bus.lut_wr_addr] = bus.lut_wr_data;
                if (int'(bus.lut_wr_tile) != mon_tile || int'(bus.lut_wr_addr) != mon_addr)
                    order_err++;
                if (bus.lut_wr_bank != exp_bank) bank_err++;
                if (mon_addr == 255) begin
                    mon_addr = 0;
                    mon_tile++;
                end else begin
                    mon_addr++;
                end
            end
            if (bus.busy) begin
                busy_cycles++;
                busy_last = cyc;
                if (!prev_busy) busy_first = cyc;
                if (bus.hist_rd_bank != exp_bank) bank_err++;
            end
            if (bus.done) begin
                done_count++;
                done_cyc = cyc;
                mon_tile = 0;
                mon_addr = 0;
            end
            prev_busy = bus.busy;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(negedge pclk);
        #1;
    endtask

    function automatic longint all_outputs;
        return longint'({bus.hist_rd_bank, bus.hist_rd_tile, bus.hist_rd_addr,
                         bus.lut_wr_en, bus.lut_wr_bank, bus.lut_wr_tile,
                         bus.lut_wr_addr, bus.lut_wr_data, bus.busy, bus.done});
    endfunction

    typedef struct {
        int         frame;
        int         tile;
        int         addr;
        logic [7:0] exp;
    } vec_t;

    localparam int NV = 24;
    vec_t vecs [NV];

    // Run one full frame and check its timing, write count, order and bank.
    task automatic run_frame(input logic [15:0] clip, input logic ppf, input bit disturb);
        int base_wr, base_oe, base_be, base_dc, base_bc, t;
        tick;
        base_wr = wr_total;
        base_oe = order_err;
        base_be = bank_err;
        base_dc = done_count;
        base_bc = busy_cycles;
        bus.clip_limit     = clip;
        bus.ping_pong_flag = ppf;
        exp_bank           = ~ppf;
        bus.start          = 1'b1;
        t                  = cyc;
        tick;
        bus.start = 1'b0;
        if (disturb) begin
            repeat (3000) tick;
            bus.ping_pong_flag = ~ppf;
            bus.clip_limit     = 16'd7;
            bus.start          = 1'b1;
            tick;
            bus.start = 1'b0;
        end
        for (int i = 0; i < 9000 && done_count == base_dc; i++) tick;
        repeat (20) tick;
        check("done_cycle", done_cyc - t, 8257);
        check("done_pulses", done_count - base_dc, 1);
        check("busy_first", busy_first - t, 1);
        check("busy_last", busy_last - t, 8256);
        check("busy_cycles", busy_cycles - base_bc, 8256);
        check("lut_writes", wr_total - base_wr, 4096);
        check("write_order", order_err - base_oe, 0);
        check("bank_errors", bank_err - base_be, 0);
        check("idle_busy", longint'(bus.busy), 0);
    endtask

    task automatic check_table(input int frame);
        for (int i = 0; i < NV; i++) begin
            if (vecs[i].frame == frame)
                check($sformatf("lut_f%0d_t%0d_a%0d", frame, vecs[i].tile, vecs[i].addr),
                      longint'(lut_cap[vecs[i].tile][vecs[i].addr]), longint'(vecs[i].exp));
        end
    endtask

    initial begin
        int  base_wr;
        bit  found;

        // frame 0: clip 1000, bank 0 (even uniform, odd spike)
        // frame 1: clip 0,    bank 1 (even spike, odd uniform)
        // frame 2: clip 1000, bank 1, after a mid-frame reset
        vecs = '{
            '{0,  0,   0, 8'd0},   '{0,  0,   1, 8'd1},   '{0,  0, 127, 8'd127},
            '{0,  0, 254, 8'd254}, '{0,  0, 255, 8'd255}, '{0,  1,   0, 8'd0},
            '{0,  1,   1, 8'd1},   '{0,  1,  23, 8'd23},  '{0,  1,  24, 8'd24},
            '{0,  1,  99, 8'd97},  '{0,  1, 100, 8'd103}, '{0,  1, 255, 8'd255},
            '{0, 15,  23, 8'd23},  '{0, 14, 127, 8'd127},
            '{1,  0,   0, 8'd0},   '{1,  0,  99, 8'd0},   '{1,  0, 100, 8'd255},
            '{1,  0, 255, 8'd255}, '{1,  1, 127, 8'd127}, '{1, 15,   1, 8'd1},
            '{2,  0,  23, 8'd23},  '{2,  0,  99, 8'd97},  '{2,  1, 127, 8'd127},
            '{2, 15, 255, 8'd255}
        };

        bus.start          = 1'b0;
        bus.ping_pong_flag = 1'b0;
        bus.clip_limit     = 16'd0;
        repeat (3) tick;
        check("reset_outputs", all_outputs(), 0);
        rst_n = 1'b1;
        repeat (2) tick;

        // Clip 1000, flag toggled and a stray start mid-frame.
        run_frame(16'd1000, 1'b1, 1'b1);
        check_table(0);

        // Clipping disabled, reading the other bank.
        run_frame(16'd0, 1'b0, 1'b0);
        check_table(1);

        // Abort in the middle of tile 5 pass 2.
        tick;
        bus.clip_limit     = 16'd1000;
        bus.ping_pong_flag = 1'b0;
        exp_bank           = 1'b1;
        bus.start          = 1'b1;
        tick;
        bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            if (bus.lut_wr_en && bus.lut_wr_tile == 4'd5 && bus.lut_wr_addr == 8'd100)
                found = 1'b1;
            else
                tick;
        end
        check("reach_tile5_p2", longint'(found), 1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", all_outputs(), 0);
        base_wr = wr_total;
        repeat (3) tick;
        check("abort_hold_outputs", all_outputs(), 0);
        rst_n = 1'b1;
        repeat (50) tick;
        check("abort_no_writes", wr_total - base_wr, 0);
        check("abort_idle_busy", longint'(bus.busy), 0);

        // Fresh start after the abort must begin at tile 0.
        run_frame(16'd1000, 1'b0, 1'b0);
        check_table(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
